// File: rtl/instr_feeder.sv
// instr_feeder: fetch-port responder fed from an instruction FIFO.
// Optional grant stall port: define INSTR_FEEDER_GNT_STALL_EN.
module instr_feeder #(
  parameter int          DEPTH     = 8,
  parameter int          LATENCY   = 1,
  parameter logic [31:0] NOP_INSTR = 32'h00000013
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     inst_valid_i,
  input  logic [31:0]              inst_data_i,
  output logic                     inst_ready_o,
  input  logic                     instr_req_i,
  input  logic [31:0]              instr_addr_i,
`ifdef INSTR_FEEDER_GNT_STALL_EN
  input  logic                     gnt_stall_i,
`endif
  output logic                     instr_gnt_o,
  output logic                     instr_rvalid_o,
  output logic [31:0]              instr_rdata_o,
  output logic [$clog2(DEPTH):0]   fifo_count_o,
  output logic [31:0]              last_addr_o,
  output logic [31:0]              fetch_count_o,
  output logic [15:0]              underflow_count_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [31:0]   r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  logic          r_pv [LATENCY];
  logic [31:0]   r_pd [LATENCY];
  logic [31:0]   r_last_addr;
  logic [31:0]   r_fetch_cnt;
  logic [15:0]   r_uf_cnt;

  logic          w_gnt;
  logic          w_push;
  logic          w_pop;
  logic          w_nop;
  logic [31:0]   w_head;

`ifdef INSTR_FEEDER_GNT_STALL_EN
  assign w_gnt = instr_req_i && !gnt_stall_i && !rst_i;
`else
  assign w_gnt = instr_req_i && !rst_i;
`endif

  // Ready looks only at the registered count, so a full FIFO
  // refuses a push even when a pop happens in the same cycle.
  assign inst_ready_o = (r_count < CW'(DEPTH));
  assign w_push       = inst_valid_i && inst_ready_o;
  assign w_pop        = w_gnt && (r_count != '0);
  assign w_nop        = w_gnt && (r_count == '0);
  assign w_head       = r_mem[r_rd_ptr];

  assign instr_gnt_o       = w_gnt;
  assign instr_rvalid_o    = r_pv[LATENCY-1];
  assign instr_rdata_o     = r_pd[LATENCY-1];
  assign fifo_count_o      = r_count;
  assign last_addr_o       = r_last_addr;
  assign fetch_count_o     = r_fetch_cnt;
  assign underflow_count_o = r_uf_cnt;

  // FIFO storage write at the tail; contents need no reset.
  always_ff @(posedge clk_i) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= inst_data_i;
    end
  end

  // Pointers, occupancy, response pipeline and fetch statistics.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
      r_last_addr <= '0;
      r_fetch_cnt <= '0;
      r_uf_cnt    <= '0;
      for (int i = 0; i < LATENCY; i++) begin
        r_pv[i] <= 1'b0;
        r_pd[i] <= '0;
      end
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase

      r_pv[0] <= w_gnt;
      if (w_gnt) begin
        r_pd[0] <= w_pop ? w_head : NOP_INSTR;
      end
      // Data only advances behind a valid, so the output word
      // holds its last delivered value between pulses.
      for (int i = 1; i < LATENCY; i++) begin
        r_pv[i] <= r_pv[i-1];
        if (r_pv[i-1]) begin
          r_pd[i] <= r_pd[i-1];
        end
      end

      if (w_gnt) begin
        r_last_addr <= instr_addr_i;
        r_fetch_cnt <= r_fetch_cnt + 32'd1;
      end
      if (w_nop && (r_uf_cnt != 16'hFFFF)) begin
        r_uf_cnt <= r_uf_cnt + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_instr_feeder.sv
// tb_instr_feeder: scoreboard bench for instr_feeder,
// one instance at LATENCY=1 and one at LATENCY=3.
module tb_instr_feeder;

  localparam logic [31:0] NOP = 32'h00000013;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        vld = 1'b0;
  logic [31:0] data = '0;
  logic        req = 1'b0;
  logic [31:0] addr = '0;
`ifdef INSTR_FEEDER_GNT_STALL_EN
  logic        stall = 1'b0;
`endif

  logic        rdy1, gnt1, rv1;
  logic [31:0] rd1, la1, fc1;
  logic [3:0]  cnt1;
  logic [15:0] uf1;
  logic        rdy3, gnt3, rv3;
  logic [31:0] rd3, la3, fc3;
  logic [3:0]  cnt3;
  logic [15:0] uf3;

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;

  typedef struct {
    logic [31:0] d;
    int          due;
  } exp_t;

  exp_t q1[$];
  exp_t q3[$];
  exp_t e1;
  exp_t e3;

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  instr_feeder #(.DEPTH(8), .LATENCY(1)) u_dut1 (
    .clk_i            (clk),
    .rst_i            (rst),
    .inst_valid_i     (vld),
    .inst_data_i      (data),
    .inst_ready_o     (rdy1),
    .instr_req_i      (req),
    .instr_addr_i     (addr),
`ifdef INSTR_FEEDER_GNT_STALL_EN
    .gnt_stall_i      (stall),
`endif
    .instr_gnt_o      (gnt1),
    .instr_rvalid_o   (rv1),
    .instr_rdata_o    (rd1),
    .fifo_count_o     (cnt1),
    .last_addr_o      (la1),
    .fetch_count_o    (fc1),
    .underflow_count_o(uf1)
  );

  instr_feeder #(.DEPTH(8), .LATENCY(3)) u_dut3 (
    .clk_i            (clk),
    .rst_i            (rst),
    .inst_valid_i     (vld),
    .inst_data_i      (data),
    .inst_ready_o     (rdy3),
    .instr_req_i      (req),
    .instr_addr_i     (addr),
`ifdef INSTR_FEEDER_GNT_STALL_EN
    .gnt_stall_i      (stall),
`endif
    .instr_gnt_o      (gnt3),
    .instr_rvalid_o   (rv3),
    .instr_rdata_o    (rd3),
    .fifo_count_o     (cnt3),
    .last_addr_o      (la3),
    .fetch_count_o    (fc3),
    .underflow_count_o(uf3)
  );

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)",
               nm, act, exp, cyc);
    end
  endtask

  // Monitor: pop the scoreboard on every response pulse.
  always @(negedge clk) begin
    if (!rst) begin
      if (rv1) begin
        if (q1.size() == 0) begin
          chk("rvalid1_unexpected", rv1, 0);
        end else begin
          e1 = q1.pop_front();
          chk("rdata1", rd1, e1.d);
          chk("rvalid1_cycle", cyc, e1.due);
        end
      end else if (q1.size() > 0 && q1[0].due <= cyc) begin
        chk("rvalid1_missing", rv1, 1);
        q1.delete(0);
      end
      if (rv3) begin
        if (q3.size() == 0) begin
          chk("rvalid3_unexpected", rv3, 0);
        end else begin
          e3 = q3.pop_front();
          chk("rdata3", rd3, e3.d);
          chk("rvalid3_cycle", cyc, e3.due);
        end
      end else if (q3.size() > 0 && q3[0].due <= cyc) begin
        chk("rvalid3_missing", rv3, 1);
        q3.delete(0);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic push(input logic [31:0] w);
    vld  = 1'b1;
    data = w;
    tick();
    vld  = 1'b0;
  endtask

  task automatic fetch(input logic [31:0] a, input logic [31:0] e);
    req  = 1'b1;
    addr = a;
    #1;
    chk("gnt1", gnt1, 1);
    chk("gnt3", gnt3, 1);
    q1.push_back('{d: e, due: cyc + 1});
    q3.push_back('{d: e, due: cyc + 3});
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    vld = 1'b0;
    req = 1'b0;
    q1.delete();
    q3.delete();
    tick();
    req = 1'b1;
    #1;
    chk("gnt_in_reset", gnt1, 0);
    req = 1'b0;
    tick();
    chk("rst_rvalid1", rv1, 0);
    chk("rst_rvalid3", rv3, 0);
    chk("rst_rdata1", rd1, 0);
    chk("rst_rdata3", rd3, 0);
    chk("rst_count", cnt1, 0);
    chk("rst_ready", rdy1, 1);
    chk("rst_last_addr", la1, 0);
    chk("rst_fetch_cnt", fc1, 0);
    chk("rst_fetch_cnt3", fc3, 0);
    chk("rst_uf_cnt", uf1, 0);
    rst = 1'b0;
  endtask

  logic [31:0] w8 [8];

  initial begin
    for (int i = 0; i < 8; i++) begin
      w8[i] = 32'h00000093 | ((i + 1) << 20);
    end

    do_reset();

    // Two queued words fetched back to back.
    push(32'h002180B3);
    push(32'h00A00093);
    chk("count_after_2_push", cnt1, 2);
    fetch(32'h0, 32'h002180B3);
    fetch(32'h4, 32'h00A00093);
    req = 1'b0;
    chk("fetch_cnt_2", fc1, 2);
    chk("count_drained", cnt1, 0);
    idle(4);

    // Underflow returns a NOP.
    fetch(32'h8, NOP);
    req = 1'b0;
    chk("uf_cnt_1", uf1, 1);
    idle(4);

    // Fill to DEPTH, extra push ignored, drain in order.
    for (int i = 0; i < 8; i++) push(w8[i]);
    chk("full_ready", rdy1, 0);
    chk("full_count", cnt1, 8);
    push(32'hDEADBEEF);
    chk("full_count_hold", cnt1, 8);
    for (int i = 0; i < 8; i++) fetch(32'h100 + 4 * i, w8[i]);
    req = 1'b0;
    chk("count_empty", cnt1, 0);
    chk("ready_again", rdy1, 1);
    fetch(32'h200, NOP);
    req = 1'b0;
    chk("uf_cnt_2", uf1, 2);
    idle(4);

    // Address capture, then reset while a response is in flight.
    fetch(32'h0A, NOP);
    fetch(32'h0E, NOP);
    req = 1'b0;
    chk("last_addr", la1, 32'h0E);
    chk("uf_cnt_4", uf1, 4);
    idle(4);
    push(32'h00C00113);
    fetch(32'h20, 32'h00C00113);
    req = 1'b0;
    do_reset();
    chk("post_rst_count3", cnt3, 0);
    chk("post_rst_uf3", uf3, 0);
    chk("post_rst_last3", la3, 0);
    idle(5);

    // Push on the same cycle as a grant to an empty FIFO.
    vld  = 1'b1;
    data = 32'h00100193;
    fetch(32'h30, NOP);
    vld  = 1'b0;
    req  = 1'b0;
    chk("push_gnt_empty_cnt", cnt1, 1);
    chk("push_gnt_empty_uf", uf1, 1);
    push(32'h00200213);
    vld  = 1'b1;
    data = 32'h00300293;
    fetch(32'h34, 32'h00100193);
    vld  = 1'b0;
    req  = 1'b0;
    chk("push_pop_cnt", cnt1, 2);
    fetch(32'h38, 32'h00200213);
    fetch(32'h3C, 32'h00300293);
    req = 1'b0;
    chk("count_zero_again", cnt3, 0);
    idle(4);

`ifdef INSTR_FEEDER_GNT_STALL_EN
    // Grant stall holds pops, counters and address.
    push(32'h00400313);
    push(32'h00500393);
    stall = 1'b1;
    req   = 1'b1;
    addr  = 32'h99;
    repeat (3) begin
      #1;
      chk("stall_gnt1", gnt1, 0);
      chk("stall_gnt3", gnt3, 0);
      tick();
    end
    chk("stall_count", cnt1, 2);
    chk("stall_fetch_cnt", fc1, 4);
    chk("stall_last_addr", la1, 32'h3C);
    stall = 1'b0;
    fetch(32'h40, 32'h00400313);
    fetch(32'h44, 32'h00500393);
    req = 1'b0;
    chk("resume_fetch_cnt", fc1, 6);
    idle(4);
`endif

    idle(6);
    chk("q1_drained", q1.size(), 0);
    chk("q3_drained", q3.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
